// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned STREAK_W = 4;

  localparam logic [BE_W-1:0] BE_FULL = 4'b1111;

  // Owner of an in-flight read slot.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned OWN_W = $bits(owner_t);

  // Request payload presented to the memory.
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_rsp_tracker.sv
// Delay line of read owners; the tail tells the arbiter whose data m_rdata carries.
module mem_rsp_tracker
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic   clk,
  input  logic   clr,
  input  owner_t push,
  output owner_t tail
);

  localparam int unsigned SR_W = OWN_W * READ_LAT;

  // Stage 0 sits in the low bits; the oldest stage falls off the top.
  logic [SR_W-1:0] sr;

  // Shift one owner tag per cycle; clear drops every in-flight read.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= {READ_LAT{OWN_W'(OWN_NONE)}};
    end else begin
      sr <= SR_W'({sr, OWN_W'(push)});
    end
  end

  assign tail = owner_t'(sr[SR_W-1 -: OWN_W]);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port synchronous memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [BE_W-1:0]   m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic                force_i;
  mem_req_t            req;
  owner_t              push_own;
  owner_t              tail_own;

  // Grant: data first, unless fetch has watched STARVE_MAX data grants go by.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    force_i = (streak == STREAK_MAX);
    if (!clr) begin
      if (i_req && (!d_req || force_i)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Steer the granted request onto the memory and tag reads with their owner.
  always_comb begin
    req      = '0;
    push_own = OWN_NONE;
    if (i_gnt) begin
      req.we    = 1'b0;
      req.be    = BE_FULL;
      req.addr  = i_addr;
      req.wdata = '0;
      push_own  = OWN_I;
    end else if (d_gnt) begin
      req.we    = d_we;
      req.be    = d_be;
      req.addr  = d_addr;
      req.wdata = d_wdata;
      if (!d_we) begin
        push_own = OWN_D;
      end
    end
  end

  assign m_en    = i_gnt | d_gnt;
  assign m_we    = req.we;
  assign m_be    = req.be;
  assign m_addr  = req.addr;
  assign m_wdata = req.wdata;

  // Count data grants that bypass a waiting fetch, saturating at the limit.
  always_comb begin
    streak_nxt = streak;
    if (!i_req || i_gnt) begin
      streak_nxt = '0;
    end else if (d_gnt && (streak != STREAK_MAX)) begin
      streak_nxt = streak + STREAK_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (clr) begin
      streak <= '0;
    end else begin
      streak <= streak_nxt;
    end
  end

  mem_rsp_tracker #(
    .READ_LAT (READ_LAT)
  ) u_tracker (
    .clk  (clk),
    .clr  (clr),
    .push (push_own),
    .tail (tail_own)
  );

  // Route returning read data to its owner; everyone else sees zero.
  always_comb begin
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    if (!clr) begin
      if (tail_own == OWN_I) begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
      if (tail_own == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 has READ_LAT=1, instance 1 has READ_LAT=3.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    owner_t      own;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        clr     [2];
  logic        i_req   [2];
  logic [31:0] i_addr  [2];
  logic        i_gnt   [2];
  logic        i_rvalid[2];
  logic [31:0] i_rdata [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [3:0]  d_be    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_gnt   [2];
  logic        d_rvalid[2];
  logic [31:0] d_rdata [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] pipe    [2][3];

  exp_t sb0[$];
  exp_t sb1[$];

  mem_arbiter #(.READ_LAT(1), .STARVE_MAX(4)) u0 (
    .clk(clk), .clr(clr[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]),
    .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_be(d_be[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_be(m_be[0]), .m_addr(m_addr[0]),
    .m_wdata(m_wdata[0]), .m_rdata(pipe[0][0])
  );

  mem_arbiter #(.READ_LAT(3), .STARVE_MAX(4)) u1 (
    .clk(clk), .clr(clr[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]),
    .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_be(d_be[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_be(m_be[1]), .m_addr(m_addr[1]),
    .m_wdata(m_wdata[1]), .m_rdata(pipe[1][2])
  );

  // Memory contents before any write.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_2000: return 32'hCAFE_F00D;
      32'h0000_0040: return 32'h1122_3344;
      32'h0000_0000: return 32'h1111_0000;
      32'h0000_0004: return 32'h2222_0004;
      32'h0000_0008: return 32'h3333_0008;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];

  function automatic logic [31:0] mem_rd(input int k, input logic [31:0] a);
    if (k == 0) return mem0.exists(a) ? mem0[a] : init_word(a);
    return mem1.exists(a) ? mem1[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Write-first memory models; read data leaves pipe stage READ_LAT-1.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
      pipe[k][0] <= 32'hBAD0_BAD0;
      if (m_en[k] && !m_we[k]) pipe[k][0] <= mem_rd(k, m_addr[k]);
    end
    if (m_en[0] && m_we[0]) mem0[m_addr[0]] = merge(mem_rd(0, m_addr[0]), m_wdata[0], m_be[0]);
    if (m_en[1] && m_we[1]) mem1[m_addr[1]] = merge(mem_rd(1, m_addr[1]), m_wdata[1], m_be[1]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check grant and memory outputs; record the response a granted read must produce.
  task automatic gchk(input int k, input string tag, input logic ei, input logic ed,
                      input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rexp);
    exp_t e;
    chk({tag, ".i_gnt"},   32'(i_gnt[k]), 32'(ei));
    chk({tag, ".d_gnt"},   32'(d_gnt[k]), 32'(ed));
    chk({tag, ".m_en"},    32'(m_en[k]),  32'(ei | ed));
    chk({tag, ".m_we"},    32'(m_we[k]),  32'(we));
    chk({tag, ".m_be"},    32'(m_be[k]),  32'(be));
    chk({tag, ".m_addr"},  m_addr[k],     a);
    chk({tag, ".m_wdata"}, m_wdata[k],    wd);
    if ((ei || ed) && !we) begin
      e.own  = ei ? OWN_I : OWN_D;
      e.data = rexp;
      e.due  = cyc + ((k == 0) ? 1 : 3);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  // Compare response outputs against the oldest outstanding expectation.
  task automatic mon(input int k);
    exp_t e;
    logic have, ei, ed;
    have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
    if (have) begin
      if (k == 0) e = sb0[0];
      else        e = sb1[0];
    end
    ei = have && (e.due == cyc) && (e.own == OWN_I);
    ed = have && (e.due == cyc) && (e.own == OWN_D);
    chk($sformatf("rsp%0d.i_rvalid@%0d", k, cyc), 32'(i_rvalid[k]), 32'(ei));
    chk($sformatf("rsp%0d.d_rvalid@%0d", k, cyc), 32'(d_rvalid[k]), 32'(ed));
    chk($sformatf("rsp%0d.i_rdata@%0d", k, cyc),  i_rdata[k], ei ? e.data : 32'h0);
    chk($sformatf("rsp%0d.d_rdata@%0d", k, cyc),  d_rdata[k], ed ? e.data : 32'h0);
    if (ei || ed) begin
      if (k == 0) void'(sb0.pop_front());
      else        void'(sb1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic drv(input int k, input logic ir, input logic [31:0] ia, input logic dr,
                     input logic dwe, input logic [3:0] dbe, input logic [31:0] da,
                     input logic [31:0] dwd);
    i_req[k] = ir;  i_addr[k] = ia;
    d_req[k] = dr;  d_we[k] = dwe; d_be[k] = dbe; d_addr[k] = da; d_wdata[k] = dwd;
  endtask

  task automatic idle(input int k);
    drv(k, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      clr[k] = 1'b1;
      idle(k);
    end
    adv();
    // Requests asserted during reset must be ignored.
    for (int k = 0; k < 2; k++) drv(k, 1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
    @(negedge clk);
    gchk(0, "rst0", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    gchk(1, "rst1", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    adv();
    for (int k = 0; k < 2; k++) begin
      clr[k] = 1'b0;
      idle(k);
    end

    // Lone fetch.
    drv(0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    gchk(0, "fetch", 1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0050_0093);
    adv();
    idle(0);
    @(negedge clk);
    gchk(0, "idle", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    adv();

    // Contention: data wins, fetch follows.
    drv(0, 1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
    @(negedge clk);
    gchk(0, "cont_d", 1'b0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 32'hCAFE_F00D);
    adv();
    d_req[0] = 1'b0;
    @(negedge clk);
    gchk(0, "cont_i", 1'b1, 1'b0, 1'b0, 4'hF, 32'h104, 32'h0, 32'h5A5A_0104);
    adv();
    idle(0);
    adv();
    adv();

    // Starvation: D D D D I D D D.
    for (int n = 0; n < 8; n++) begin
      drv(0, 1'b1, (n <= 4) ? 32'h200 : 32'h204, 1'b1, 1'b0, 4'hF, 32'h300 + 32'(4 * n), 32'h0);
      @(negedge clk);
      if (n == 4)
        gchk(0, $sformatf("starve%0d", n), 1'b1, 1'b0, 1'b0, 4'hF, 32'h200, 32'h0,
             init_word(32'h200));
      else
        gchk(0, $sformatf("starve%0d", n), 1'b0, 1'b1, 1'b0, 4'hF, 32'h300 + 32'(4 * n),
             32'h0, init_word(32'h300 + 32'(4 * n)));
      adv();
    end
    idle(0);
    adv();
    adv();

    // Partial write then immediate read of the same word.
    drv(0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
    @(negedge clk);
    gchk(0, "wr", 1'b0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 32'h0);
    adv();
    drv(0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    @(negedge clk);
    gchk(0, "rd_after_wr", 1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h1122_BEEF);
    adv();
    idle(0);
    adv();
    adv();

    // Latency 3: three back-to-back fetches.
    for (int n = 0; n < 3; n++) begin
      drv(1, 1'b1, 32'(4 * n), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      gchk(1, $sformatf("lat3_%0d", n), 1'b1, 1'b0, 1'b0, 4'hF, 32'(4 * n), 32'h0,
           init_word(32'(4 * n)));
      adv();
    end
    idle(1);
    repeat (4) adv();

    // Mid-flight reset drops the outstanding data read.
    drv(1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
    @(negedge clk);
    gchk(1, "mf_rd", 1'b0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 32'hCAFE_F00D);
    adv();
    clr[1] = 1'b1;
    drv(1, 1'b1, 32'h8, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
    @(negedge clk);
    sb1.delete();
    gchk(1, "mf_clr", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    adv();
    clr[1] = 1'b0;
    drv(1, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    gchk(1, "after_clr", 1'b1, 1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h3333_0008);
    adv();
    idle(1);
    repeat (6) adv();

    chk("sb0_drained", 32'(sb0.size()), 32'h0);
    chk("sb1_drained", 32'(sb1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and data port, so the design can replace separate imem/dmem with a unified memory.
- Sits between riscv and the unified memory, at the same level as the memory instances in the top level.
- Per cycle: grants at most one requester, forwards its address, write data and byte enable, and tracks in-flight reads so each read response returns to its owner.
- Data side has priority; a starvation counter guarantees fetch progress.

Parameters:
- READ_LAT, 1, memory read latency in cycles from m_en to m_rdata valid; legal range 1..4.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock.
- clr  in  1  reset; synchronous, active-high.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  32  fetch read data.
- d_req  in  1  data request; held with its attributes until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  byte enable.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid; never asserted for writes.
- d_rdata  out  32  data read data.
- m_en  out  1  memory access this cycle.
- m_we  out  1  memory write.
- m_be  out  4  memory byte enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid READ_LAT cycles after a read m_en.

Behaviour:
- Grant is combinational in the request cycle; m_* carry the granted request in that same cycle. At most one of i_gnt/d_gnt is high.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: d wins unless streak == STARVE_MAX, in which case i wins.
- streak (4-bit register):
  - +1 on a d grant while i_req = 1.
  - Cleared on an i grant, or in any cycle with i_req = 0.
  - Saturates at STARVE_MAX.
- Fetch access: m_we = 0, m_be = 4'b1111, m_addr = i_addr, m_wdata = 0.
- Data access: m_we = d_we, m_be = d_be, m_addr = d_addr, m_wdata = d_wdata.
- No grant: all m_* outputs are 0.
- Addresses and byte enables pass through unchanged; no alignment checks.
- Response tracking:
  - Owner tag shift register READ_LAT deep.
  - On a granted read, push OWN_I or OWN_D; otherwise push OWN_NONE, which covers writes and idle cycles.
  - At the tail of the register, the owner's rvalid is asserted for 1 cycle and its rdata = m_rdata.
  - Non-owner rdata = 0; rdata = 0 whenever its rvalid = 0.
- Back-to-back reads are fully pipelined: one grant per cycle, responses return in grant order, one per cycle.
- A write followed immediately by a read to the same address returns the written data; the memory is write-first, and the arbiter imposes no bubble.
- Simultaneous grant and response in the same cycle are independent.
- Reset (clr = 1 at a clock edge):
  - streak = 0 and all tags = OWN_NONE; in-flight reads are discarded.
  - While clr = 1: i_gnt = d_gnt = 0, m_en = 0, all m_* = 0, i_rvalid = d_rvalid = 0, rdata = 0.
- First grant is possible in the cycle after clr deasserts.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_I, OWN_D}.
  - Constants BE_FULL = 4'b1111 and STREAK_W = 4.
- Sub-module mem_rsp_tracker: parameterised READ_LAT-deep owner_t shift register with synchronous clear. Outputs the tail owner; the top uses it to steer rvalid/rdata.
- Arbitration and streak logic stay in mem_arbiter.

Test Plan:
- Lone fetch (READ_LAT = 1):
  - Stimulus: i_req = 1, i_addr = 0x100, memory word 0x00500093.
  - Required: i_gnt same cycle, m_addr = 0x100, m_be = 0xF; next cycle i_rvalid = 1, i_rdata = 0x00500093, d_rvalid = 0.
- Contention:
  - Stimulus: i_req and d_req (read of 0x2000) in the same cycle, streak = 0.
  - Required: d_gnt = 1, i_gnt = 0; i granted the following cycle; responses arrive d then i on consecutive cycles.
- Starvation:
  - Stimulus: i_req and d_req held high for 8 cycles, STARVE_MAX = 4.
  - Required grant sequence: D, D, D, D, I, D, D, D; streak returns to 0 after the I grant.
- Data write then read:
  - Stimulus: write 0xDEADBEEF with be = 4'b0011 to 0x40 (prior contents 0x11223344); next cycle read 0x40.
  - Required: no d_rvalid for the write; read returns 0x1122BEEF.
- Latency 3 (READ_LAT = 3):
  - Stimulus: 3 consecutive fetches to 0x0, 0x4, 0x8.
  - Required: i_rvalid high in cycles 3, 4, 5 with matching data, in order.
- Mid-flight reset:
  - Stimulus: READ_LAT = 3, data read granted, then clr = 1 for one cycle one cycle later.
  - Required: no d_rvalid ever produced for that read; all outputs 0 during clr; a new request is granted the cycle after clr falls.
